// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: shares one AXI bridge port between icache reads and dcache reads/writes
module cache_axi_arbiter #(
  parameter int RR_EN     = 1,
  parameter int MAX_BEATS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic [2:0]   i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic         i_ret_last,
  output logic [31:0]  i_ret_data,
  input  logic         d_rd_req,
  input  logic [2:0]   d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic         d_ret_last,
  output logic [31:0]  d_ret_data,
  input  logic         d_wr_req,
  input  logic [2:0]   d_wr_type,
  input  logic [31:0]  d_wr_addr,
  input  logic [3:0]   d_wr_wstrb,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_rdy,
  output logic         rd_req,
  output logic [2:0]   rd_type,
  output logic [31:0]  rd_addr,
  input  logic         rd_rdy,
  input  logic         ret_valid,
  input  logic         ret_last,
  input  logic [31:0]  ret_data,
  output logic         wr_req,
  output logic [2:0]   wr_type,
  output logic [31:0]  wr_addr,
  output logic [3:0]   wr_wstrb,
  output logic [127:0] wr_data,
  input  logic         wr_rdy,
  output logic         err,
  output logic [2:0]   beat_cnt
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [2:0] MAX_B  = 3'(MAX_BEATS);

  logic [1:0] state;
  logic       prio_d;
  logic       idle;
  logic       sel_d;
  logic       own_i;
  logic       own_d;

  assign idle  = state == IDLE;
  assign own_i = state == BUSY_I;
  assign own_d = state == BUSY_D;
  assign sel_d = d_rd_req && (!i_rd_req || prio_d);

  assign rd_req   = idle && (i_rd_req || d_rd_req);
  assign rd_type  = rd_req ? (sel_d ? d_rd_type : i_rd_type) : 3'd0;
  assign rd_addr  = rd_req ? (sel_d ? d_rd_addr : i_rd_addr) : 32'd0;
  assign i_rd_rdy = rd_req && !sel_d && rd_rdy;
  assign d_rd_rdy = rd_req && sel_d && rd_rdy;

  assign i_ret_valid = own_i && ret_valid;
  assign i_ret_last  = own_i && ret_last;
  assign i_ret_data  = own_i ? ret_data : 32'd0;
  assign d_ret_valid = own_d && ret_valid;
  assign d_ret_last  = own_d && ret_last;
  assign d_ret_data  = own_d ? ret_data : 32'd0;

  assign wr_req   = d_wr_req;
  assign wr_type  = d_wr_type;
  assign wr_addr  = d_wr_addr;
  assign wr_wstrb = d_wr_wstrb;
  assign wr_data  = d_wr_data;
  assign d_wr_rdy = wr_rdy;

  // grant tracking, burst beat counting and sticky protocol error
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      prio_d   <= 1'b1;
      err      <= 1'b0;
      beat_cnt <= 3'd0;
    end else if (idle) begin
      if (ret_valid) err <= 1'b1;
      if (rd_req && rd_rdy) begin
        state    <= sel_d ? BUSY_D : BUSY_I;
        beat_cnt <= 3'd0;
        if (RR_EN != 0) prio_d <= !sel_d;
      end
    end else if (ret_valid) begin
      beat_cnt <= (beat_cnt == 3'd7) ? beat_cnt : beat_cnt + 3'd1;
      if (ret_last) state <= IDLE;
      else if (beat_cnt >= MAX_B) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: scoreboard bench for the icache/dcache AXI read arbiter
module tb_cache_axi_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_rd_req = 0, d_rd_req = 0, d_wr_req = 0, rd_rdy = 0, ret_valid = 0, ret_last = 0, wr_rdy = 0;
  logic [2:0] i_rd_type = 0, d_rd_type = 0, d_wr_type = 0;
  logic [31:0] i_rd_addr = 0, d_rd_addr = 0, d_wr_addr = 0, ret_data = 0;
  logic [3:0] d_wr_wstrb = 0;
  logic [127:0] d_wr_data = 0;
  logic i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last, d_wr_rdy, rd_req, wr_req, err;
  logic [31:0] i_ret_data, d_ret_data, rd_addr, wr_addr;
  logic [2:0] rd_type, wr_type, beat_cnt;
  logic [3:0] wr_wstrb;
  logic [127:0] wr_data;
  logic fp_i_rd_rdy, fp_i_ret_valid, fp_i_ret_last, fp_d_rd_rdy, fp_d_ret_valid, fp_d_ret_last, fp_d_wr_rdy, fp_rd_req, fp_wr_req, fp_err;
  logic [31:0] fp_i_ret_data, fp_d_ret_data, fp_rd_addr, fp_wr_addr;
  logic [2:0] fp_rd_type, fp_wr_type, fp_beat_cnt;
  logic [3:0] fp_wr_wstrb;
  logic [127:0] fp_wr_data;

  logic [34:0] sb[$];
  logic [34:0] e;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  cache_axi_arbiter #(.RR_EN(1), .MAX_BEATS(4)) dut (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .err(err), .beat_cnt(beat_cnt)
  );

  cache_axi_arbiter #(.RR_EN(0), .MAX_BEATS(4)) dut_fp (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(fp_i_rd_rdy),
    .i_ret_valid(fp_i_ret_valid), .i_ret_last(fp_i_ret_last), .i_ret_data(fp_i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(fp_d_rd_rdy),
    .d_ret_valid(fp_d_ret_valid), .d_ret_last(fp_d_ret_last), .d_ret_data(fp_d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr), .d_wr_wstrb(d_wr_wstrb),
    .d_wr_data(d_wr_data), .d_wr_rdy(fp_d_wr_rdy),
    .rd_req(fp_rd_req), .rd_type(fp_rd_type), .rd_addr(fp_rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(fp_wr_req), .wr_type(fp_wr_type), .wr_addr(fp_wr_addr), .wr_wstrb(fp_wr_wstrb), .wr_data(fp_wr_data),
    .wr_rdy(wr_rdy), .err(fp_err), .beat_cnt(fp_beat_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    i_rd_req = 0; d_rd_req = 0; rd_rdy = 0; ret_valid = 0; ret_last = 0;
    step();
    step();
    reset = 0;
  endtask

  task automatic beat(input logic [31:0] dat, input logic last, input logic [1:0] own);
    ret_valid = 1;
    ret_data = dat;
    ret_last = last;
    if (own != 2'b00) sb.push_back({own, last, dat});
    step();
    ret_valid = 0;
    ret_last = 0;
  endtask

  // return beats are matched in order against the expected owner/data/last
  always @(negedge clock) begin
    if (!reset && (i_ret_valid || d_ret_valid)) begin
      if (sb.size() == 0) check("ret_unexpected", {i_ret_valid, d_ret_valid}, 2'b00);
      else begin
        e = sb.pop_front();
        check("ret_owner", {i_ret_valid, d_ret_valid}, e[34:33]);
        check("ret_data", e[34] ? i_ret_data : d_ret_data, e[31:0]);
        check("ret_last", e[34] ? i_ret_last : d_ret_last, e[32]);
      end
    end
  end

  initial begin
    d_wr_req = 1; d_wr_addr = 32'h44; wr_rdy = 1;
    step();
    @(negedge clock);
    check("rst_wr_pass", {wr_req, wr_addr, d_wr_rdy}, {1'b1, 32'h44, 1'b1});
    d_wr_req = 0; wr_rdy = 0;
    do_reset();
    @(negedge clock);
    check("rst_rd_req", rd_req, 0);
    check("rst_err", err, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_rdy", {i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid}, 4'b0);

    step();
    d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h1C000100; rd_rdy = 1;
    @(negedge clock);
    check("t1_rd_req", rd_req, 1);
    check("t1_rd_addr", rd_addr, 32'h1C000100);
    check("t1_rd_type", rd_type, 3'b010);
    check("t1_rdy", {i_rd_rdy, d_rd_rdy}, 2'b01);
    step();
    @(negedge clock);
    check("t1_busy_no_req", {rd_req, d_rd_rdy}, 2'b00);
    step();
    beat(32'hDEADBEEF, 1, 2'b01);
    rd_rdy = 0;
    @(negedge clock);
    check("t1_idle_again", {rd_req, d_rd_rdy}, 2'b10);
    step();
    d_rd_req = 0;

    do_reset();
    i_rd_req = 1; d_rd_req = 1; i_rd_type = 3'b100; d_rd_type = 3'b100;
    i_rd_addr = 32'h1000; d_rd_addr = 32'h2000; rd_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("t2_d_rdy", d_rd_rdy, (k % 2) == 0);
      check("t2_i_rdy", i_rd_rdy, (k % 2) == 1);
      check("t2_addr", rd_addr, (k % 2) == 0 ? 32'h2000 : 32'h1000);
      check("t3_fp_rdy", {fp_i_rd_rdy, fp_d_rd_rdy}, 2'b01);
      if (k > 0) check("t2_beat_cnt", beat_cnt, 4);
      step();
      for (int b = 0; b < 4; b++) beat(32'(k * 16 + b), b == 3, (k % 2) == 0 ? 2'b01 : 2'b10);
    end
    i_rd_req = 0; d_rd_req = 0;

    i_rd_req = 1; i_rd_addr = 32'h3000;
    @(negedge clock);
    check("t4_i_rdy", i_rd_rdy, 1);
    step();
    i_rd_req = 0; d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h80; d_wr_wstrb = 4'hF;
    d_wr_data = 128'h0123456789ABCDEF_FEDCBA9876543210; wr_rdy = 1;
    @(negedge clock);
    check("t4_wr_req", {wr_req, d_wr_rdy}, 2'b11);
    check("t4_wr_addr", {wr_type, wr_addr, wr_wstrb}, {3'b100, 32'h80, 4'hF});
    check("t4_wr_data", wr_data, 128'h0123456789ABCDEF_FEDCBA9876543210);
    for (int b = 0; b < 4; b++) beat(32'hA0 + 32'(b), b == 3, 2'b10);
    d_wr_req = 0; wr_rdy = 0;
    @(negedge clock);
    check("t4_wr_off", {wr_req, d_wr_rdy}, 2'b00);
    check("t5_err_clear", err, 0);
    step();

    beat(32'h5A5A5A5A, 1, 2'b00);
    @(negedge clock);
    check("t5_err_stray", err, 1);
    step();
    step();
    @(negedge clock);
    check("t5_err_sticky", err, 1);
    do_reset();
    @(negedge clock);
    check("t5_err_reset", err, 0);
    d_rd_req = 1; d_rd_addr = 32'h5000; rd_rdy = 1;
    step();
    d_rd_req = 0;
    for (int b = 0; b < 4; b++) beat(32'h50 + 32'(b), 0, 2'b01);
    @(negedge clock);
    check("t5_err_at_max", {err, beat_cnt}, {1'b0, 3'd4});
    beat(32'h54, 0, 2'b01);
    @(negedge clock);
    check("t5_err_over", {err, beat_cnt}, {1'b1, 3'd5});
    beat(32'h55, 1, 2'b01);
    @(negedge clock);
    check("t5_err_hold", {err, beat_cnt, rd_req}, {1'b1, 3'd6, 1'b0});

    do_reset();
    i_rd_req = 1; i_rd_addr = 32'h4000; rd_rdy = 1;
    step();
    i_rd_req = 0;
    beat(32'h61, 0, 2'b10);
    ret_valid = 1; ret_data = 32'h62; reset = 1;
    step();
    reset = 0; ret_data = 32'h63; ret_last = 1; i_rd_req = 1; rd_rdy = 0;
    @(negedge clock);
    check("t6_no_ret", {i_ret_valid, d_ret_valid}, 2'b00);
    check("t6_no_rdy", {i_rd_rdy, d_rd_rdy}, 2'b00);
    check("t6_idle", {rd_req, beat_cnt}, {1'b1, 3'd0});
    step();
    ret_valid = 0; ret_last = 0; i_rd_req = 0;
    @(negedge clock);
    check("t6_err_stray", err, 1);

    check("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
